vend_arbiter: RTL and testbench

- Front-end controller for the single `Vending` core.
- After reset it preloads the core's product prices over DI.
- It then shares the core between two customer panels (requesters) using round-robin arbitration.
- For each granted transaction it issues the money/select/return word to the core, waits for the core's change/product response (with timeout), and returns the result to the owning panel.

---
 rtl/vend_arbiter.sv | 158 +++++++++++++++
 tb/tb_vend_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// Purpose : front end for one Vending core; loads prices after reset, then shares the core
//           between two panels with round-robin arbitration and returns each result.
// Latency : grant 1 cycle after req sampled, core word 1 cycle later, done 2 edges after response.
// Backpres: panels hold req until done; the core gets TIMEOUT cycles, then money is refunded.
// Ports   : clk/rst; per panel reqN, miN, selN, reN in and gntN, doneN out; shared result
//           res_mo/res_po/res_to (valid with done); core_di/mi/sel/re out, core_mo/po in.
module vend_arbiter #(
  parameter int          PRODUCTNUM = 3,
  parameter logic [7:0]  PRICE0     = 8'd10,
  parameter logic [7:0]  PRICE1     = 8'd15,
  parameter logic [7:0]  PRICE2     = 8'd20,
  parameter int          TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] mi0,
  input  logic [7:0] mi1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic       re0,
  input  logic       re1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res_mo,
  output logic [1:0] res_po,
  output logic       res_to,
  output logic [7:0] core_di,
  output logic [7:0] core_mi,
  output logic [1:0] core_sel,
  output logic       core_re,
  input  logic [7:0] core_mo,
  input  logic [1:0] core_po
);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic [1:0] ld_cnt;
  logic       rr;        // panel favoured when both request
  logic       owner;
  logic [7:0] l_mi;
  logic [1:0] l_sel;
  logic       l_re;
  logic [7:0] to_cnt;
  logic [7:0] c_mo;      // result captured in WAIT, presented in the done cycle
  logic [1:0] c_po;
  logic       c_to;

  logic pick;
  assign pick = (req0 && req1) ? rr : req1;

  function automatic logic [7:0] price(input logic [1:0] idx);
    case (idx)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      default: price = PRICE2;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LOAD;
      ld_cnt   <= 2'd0;
      rr       <= 1'b0;
      owner    <= 1'b0;
      l_mi     <= 8'd0;
      l_sel    <= 2'd0;
      l_re     <= 1'b0;
      to_cnt   <= 8'd0;
      c_mo     <= 8'd0;
      c_po     <= 2'd0;
      c_to     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      res_mo   <= 8'd0;
      res_po   <= 2'd0;
      res_to   <= 1'b0;
      core_di  <= 8'd0;
      core_mi  <= 8'd0;
      core_sel <= 2'd0;
      core_re  <= 1'b0;
    end else begin
      // Pulses and the core word are single-cycle unless a state re-drives them.
      done0    <= 1'b0;
      done1    <= 1'b0;
      res_mo   <= 8'd0;
      res_po   <= 2'd0;
      res_to   <= 1'b0;
      core_di  <= 8'd0;
      core_mi  <= 8'd0;
      core_sel <= 2'd0;
      core_re  <= 1'b0;
      case (state)
        S_LOAD: begin
          if (ld_cnt == 2'(PRODUCTNUM)) begin
            state <= S_IDLE;
          end else begin
            core_di <= price(ld_cnt);
            ld_cnt  <= ld_cnt + 2'd1;
          end
        end
        S_IDLE: begin
          // Previous owner's grant ends here (its done cycle); a new one may start at once.
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (req0 || req1) begin
            owner <= pick;
            gnt0  <= ~pick;
            gnt1  <= pick;
            l_mi  <= pick ? mi1  : mi0;
            l_sel <= pick ? sel1 : sel0;
            l_re  <= pick ? re1  : re0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          core_mi  <= l_mi;
          core_sel <= l_sel;
          core_re  <= l_re;
          to_cnt   <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (core_po != 2'd0 || core_mo != 8'd0) begin
            c_mo  <= core_mo;
            c_po  <= core_po;
            c_to  <= 1'b0;
            state <= S_DONE;
          end else if (to_cnt == 8'(TIMEOUT - 1)) begin
            c_mo  <= l_mi;  // refund the inserted amount
            c_po  <= 2'd0;
            c_to  <= 1'b1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_DONE: begin
          done0  <= ~owner;
          done1  <= owner;
          res_mo <= c_mo;
          res_po <= c_po;
          res_to <= c_to;
          rr     <= ~owner;  // favour the other panel next time
          state  <= S_IDLE;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// Purpose : self-checking bench for vend_arbiter with a transaction-level reference model.
// Latency : model predicts grant, issue and done cycles from the arbitration rules.
// Backpres: the bench plays both panels and the core; the core may answer late or never.
module tb_vend_arbiter;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] mi0, mi1;
  logic [1:0] sel0, sel1;
  logic       re0, re1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] res_mo;
  logic [1:0] res_po;
  logic       res_to;
  logic [7:0] core_di, core_mi;
  logic [1:0] core_sel;
  logic       core_re;
  logic [7:0] core_mo;
  logic [1:0] core_po;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit         preq[2];
  logic [7:0] pmi[2];
  logic [1:0] psel[2];
  logic       pre[2];
  int         fav;

  always #5 clk = ~clk;

  vend_arbiter #(.PRODUCTNUM(3), .PRICE0(8'd10), .PRICE1(8'd15), .PRICE2(8'd20),
                 .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .mi0(mi0), .mi1(mi1),
    .sel0(sel0), .sel1(sel1), .re0(re0), .re1(re1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_mo(res_mo), .res_po(res_po), .res_to(res_to),
    .core_di(core_di), .core_mi(core_mi), .core_sel(core_sel), .core_re(core_re),
    .core_mo(core_mo), .core_po(core_po)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);

  task automatic apply();
    req0 = preq[0]; mi0 = pmi[0]; sel0 = psel[0]; re0 = pre[0];
    req1 = preq[1]; mi1 = pmi[1]; sel1 = psel[1]; re1 = pre[1];
  endtask

  task automatic set_panel(input int p, input logic [7:0] mi, input logic [1:0] sel, input logic re);
    preq[p] = 1'b1; pmi[p] = mi; psel[p] = sel; pre[p] = re;
    apply();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_gnt"},  {30'd0, gnt1, gnt0}, 32'd0);
    chk({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
    chk({tag, "_res"},  {21'd0, res_to, res_po, res_mo}, 32'd0);
    chk({tag, "_core"}, {13'd0, core_re, core_sel, core_mi, core_di}, 32'd0);
  endtask

  // Price preload: 10, 15, 20 then 0, with no grant even if a panel requests.
  task automatic load_chk();
    logic [7:0] exp_di[4];
    exp_di[0] = 8'd10; exp_di[1] = 8'd15; exp_di[2] = 8'd20; exp_di[3] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("load_di", 32'(core_di), 32'(exp_di[i]));
      chk("load_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("load_done", {30'd0, done1, done0}, 32'd0);
    end
    fav = 0;
  endtask

  // One granted transaction; the core answers d WAIT edges after issue (never if d >= TIMEOUT).
  task automatic run_one(input int d, input logic [7:0] mo, input logic [1:0] po,
                         input bit drop, output int own);
    logic [7:0] emi;
    logic [1:0] esel;
    logic       ere;
    bit         resp;
    int         tdone;
    own   = (preq[0] && preq[1]) ? fav : (preq[1] ? 1 : 0);
    emi   = pmi[own]; esel = psel[own]; ere = pre[own];
    resp  = (d < TIMEOUT) && (mo != 8'd0 || po != 2'd0);
    tdone = resp ? d + 2 : TIMEOUT + 1;
    @(negedge clk);
    chk("gnt", {30'd0, gnt1, gnt0}, (own == 1) ? 32'd2 : 32'd1);
    @(negedge clk);
    chk("issue", {21'd0, core_re, core_sel, core_mi}, {21'd0, ere, esel, emi});
    if (resp && d == 0) begin core_mo = mo; core_po = po; end
    if (drop) begin
      // Panel abandons the request and scribbles its inputs; the latched word must win.
      preq[own] = 1'b0; pmi[own] = 8'($urandom); psel[own] = 2'($urandom); pre[own] = 1'($urandom);
      apply();
    end
    for (int i = 1; i <= tdone; i++) begin
      @(negedge clk);
      core_mo = (resp && i == d) ? mo : 8'd0;
      core_po = (resp && i == d) ? po : 2'd0;
      if (i == 1) chk("issue_once", {21'd0, core_re, core_sel, core_mi}, 32'd0);
      chk("gnt_hold", {30'd0, gnt1, gnt0}, (own == 1) ? 32'd2 : 32'd1);
      if (i < tdone) begin
        chk("early_done", {30'd0, done1, done0}, 32'd0);
      end else begin
        chk("done", {30'd0, done1, done0}, (own == 1) ? 32'd2 : 32'd1);
        chk("res_mo", 32'(res_mo), resp ? 32'(mo) : 32'(emi));
        chk("res_po", 32'(res_po), resp ? 32'(po) : 32'd0);
        chk("res_to", 32'(res_to), resp ? 32'd0 : 32'd1);
      end
    end
    fav = 1 - own;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    zero_chk("idle");
  endtask

  initial begin
    int own;
    int d;
    logic [7:0] mo;
    logic [1:0] po;
    for (int p = 0; p < 2; p++) begin
      preq[p] = 1'b0; pmi[p] = 8'd0; psel[p] = 2'd0; pre[p] = 1'b0;
    end
    apply();
    core_mo = 8'd0; core_po = 2'd0;
    fav = 0;
    rst = 1'b1;
    set_panel(0, 8'd20, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    zero_chk("rst");
    rst = 1'b0;
    load_chk();
    preq[0] = 1'b0; apply();

    // Directed: purchase, timeout refund, return with no product, late boundary response.
    set_panel(0, 8'd20, 2'd1, 1'b0);
    run_one(2, 8'd10, 2'd1, 1'b0, own);
    preq[own] = 1'b0; apply();
    idle_chk();
    set_panel(1, 8'd7, 2'd2, 1'b0);
    run_one(255, 8'd0, 2'd0, 1'b0, own);
    preq[own] = 1'b0; apply();
    idle_chk();
    set_panel(0, 8'd30, 2'd3, 1'b0);
    run_one(TIMEOUT - 1, 8'd3, 2'd2, 1'b1, own);
    idle_chk();
    set_panel(0, 8'd0, 2'd0, 1'b0);
    run_one(255, 8'd0, 2'd0, 1'b0, own);
    preq[own] = 1'b0; apply();
    idle_chk();
    set_panel(1, 8'd0, 2'd0, 1'b1);
    run_one(0, 8'd5, 2'd0, 1'b0, own);
    preq[own] = 1'b0; apply();
    idle_chk();

    // Both requesting continuously: grants alternate starting with panel0.
    set_panel(0, 8'd40, 2'd1, 1'b0);
    set_panel(1, 8'd50, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_one(int'($urandom_range(0, 4)), 8'($urandom_range(1, 255)), 2'($urandom), 1'b0, own);
      chk("rr_order", 32'(own), 32'(k % 2));
    end
    preq[0] = 1'b0; preq[1] = 1'b0; apply();
    idle_chk();

    // Reset during WAIT: immediate zeroing, no done, prices reloaded.
    set_panel(0, 8'd33, 2'd1, 1'b0);
    @(negedge clk);
    chk("mid_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    zero_chk("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    load_chk();
    preq[0] = 1'b0; apply();

    // Randomised traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++)
        if (!preq[p] && $urandom_range(0, 1) == 1)
          set_panel(p, 8'($urandom), 2'($urandom), 1'($urandom));
      if (!preq[0] && !preq[1])
        set_panel(int'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom));
      d  = int'($urandom_range(0, 20));
      mo = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      po = 2'($urandom);
      run_one(d, mo, po, 1'($urandom), own);
      preq[own] = 1'b0; apply();
      if (!preq[0] && !preq[1] && $urandom_range(0, 1) == 1) idle_chk();
    end
    preq[0] = 1'b0; preq[1] = 1'b0; apply();
    idle_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
